// File: rtl/status_monitor.sv
// status_monitor: rstatus register with bex forwarding and a timestamped
// event FIFO that logs every nonzero status write.
module status_monitor #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned DROP_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     status_we,
    input  logic [26:0]              status_in,
    input  logic                     status_clr,
    input  logic                     bex_valid,
    input  logic [26:0]              bex_target,
    output logic                     bex_taken,
    output logic [26:0]              bex_pc,
    output logic [26:0]              status_q,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [26:0]              evt_code,
    output logic [TS_W-1:0]          evt_time,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [TS_W-1:0]   r_ts;
    logic [26:0]       r_status;
    logic              r_bex_taken;
    logic [26:0]       r_bex_pc;
    logic [26:0]       r_code [DEPTH];
    logic [TS_W-1:0]   r_time [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [DROP_W-1:0] r_drop;

    logic [26:0]       w_eff;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_push_ok;
    logic              w_drop;

    // Combinational view of status for bex and the FIFO push/pop decisions
    always_comb begin
        w_eff = r_status;
        if (status_we) begin
            w_eff = status_in;
        end else if (status_clr) begin
            w_eff = '0;
        end
        w_empty   = (r_count == '0);
        w_full    = (r_count == CW'(DEPTH));
        w_push    = status_we && (status_in != '0);
        w_pop     = !w_empty && evt_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle
        w_push_ok = w_push && (!w_full || w_pop);
        w_drop    = w_push && w_full && !w_pop;
    end

    // Free-running timestamp
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    // Architectural status register; write has priority over clear
    always_ff @(posedge clock) begin
        if (reset) begin
            r_status <= '0;
        end else if (status_we) begin
            r_status <= status_in;
        end else if (status_clr) begin
            r_status <= '0;
        end
    end

    // bex resolution against the forwarded status value
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bex_taken <= 1'b0;
            r_bex_pc    <= '0;
        end else begin
            r_bex_taken <= bex_valid && (w_eff != '0);
            if (bex_valid && (w_eff != '0)) begin
                r_bex_pc <= bex_target;
            end
        end
    end

    // Event FIFO storage
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_code[r_wptr] <= status_in;
            r_time[r_wptr] <= r_ts;
        end
    end

    // Event FIFO pointers, occupancy and saturating drop counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + DROP_W'(1);
            end
        end
    end

    assign bex_taken  = r_bex_taken;
    assign bex_pc     = r_bex_pc;
    assign status_q   = r_status;
    assign evt_valid  = !w_empty;
    assign evt_code   = w_empty ? '0 : r_code[r_rptr];
    assign evt_time   = w_empty ? '0 : r_time[r_rptr];
    assign evt_count  = r_count;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_status_monitor.sv
// Directed bench for status_monitor (DEPTH=4, TS_W=16, DROP_W=8).
module tb_status_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        status_we;
    logic [26:0] status_in;
    logic        status_clr;
    logic        bex_valid;
    logic [26:0] bex_target;
    logic        bex_taken;
    logic [26:0] bex_pc;
    logic [26:0] status_q;
    logic        evt_valid;
    logic        evt_ready;
    logic [26:0] evt_code;
    logic [15:0] evt_time;
    logic [2:0]  evt_count;
    logic [7:0]  drop_count;

    // Bench model of the DUT timestamp during the current cycle
    logic [15:0] ts = '0;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [26:0] exp_code1 [4] = '{27'h1, 27'h2, 27'h0F1, 27'h3};
    logic [15:0] exp_time1 [4] = '{16'd5, 16'd7, 16'd8, 16'd9};
    logic [26:0] exp_code2 [4] = '{27'h6, 27'h7, 27'h8, 27'hC};
    logic [15:0] exp_time2 [4] = '{16'd1, 16'd2, 16'd3, 16'd7};

    status_monitor #(.DEPTH(4), .TS_W(16), .DROP_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .status_we  (status_we),
        .status_in  (status_in),
        .status_clr (status_clr),
        .bex_valid  (bex_valid),
        .bex_target (bex_target),
        .bex_taken  (bex_taken),
        .bex_pc     (bex_pc),
        .status_q   (status_q),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_time   (evt_time),
        .evt_count  (evt_count),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
        if (reset) ts = '0;
        else       ts = ts + 16'd1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [26:0] v);
        status_we = 1'b1;
        status_in = v;
        tick;
        status_we = 1'b0;
        status_in = '0;
    endtask

    initial begin
        reset = 1'b1; status_we = 1'b0; status_in = '0; status_clr = 1'b0;
        bex_valid = 1'b0; bex_target = '0; evt_ready = 1'b0;
        tick;
        tick;
        check("rst_status", 32'(status_q), 32'h0);
        check("rst_taken", 32'(bex_taken), 32'h0);
        check("rst_pc", 32'(bex_pc), 32'h0);
        check("rst_valid", 32'(evt_valid), 32'h0);
        check("rst_count", 32'(evt_count), 32'h0);
        check("rst_drop", 32'(drop_count), 32'h0);
        check("rst_code", 32'(evt_code), 32'h0);
        check("rst_time", 32'(evt_time), 32'h0);
        reset = 1'b0;

        // FIFO order and timestamps: writes at t=5..9, zero write skipped
        repeat (5) tick;
        push(27'h1);
        push(27'h0);
        push(27'h2);
        push(27'h0F1);
        push(27'h3);
        check("order_count", 32'(evt_count), 32'd4);
        check("order_valid", 32'(evt_valid), 32'h1);
        check("order_status", 32'(status_q), 32'h3);
        check("order_drop", 32'(drop_count), 32'h0);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain1_code", 32'(evt_code), 32'(exp_code1[i]));
            check("drain1_time", 32'(evt_time), 32'(exp_time1[i]));
            tick;
        end
        check("drain1_valid", 32'(evt_valid), 32'h0);
        check("drain1_count", 32'(evt_count), 32'h0);
        check("drain1_code0", 32'(evt_code), 32'h0);
        tick;
        check("empty_pop_count", 32'(evt_count), 32'h0);
        check("empty_pop_valid", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;

        // Forwarding: write and bex in the same cycle
        status_clr = 1'b1;
        tick;
        status_clr = 1'b0;
        check("fwd_pre_status", 32'(status_q), 32'h0);
        status_we = 1'b1; status_in = 27'h3; bex_valid = 1'b1; bex_target = 27'h100;
        tick;
        status_we = 1'b0; status_in = '0; bex_valid = 1'b0; bex_target = '0;
        check("fwd_taken", 32'(bex_taken), 32'h1);
        check("fwd_pc", 32'(bex_pc), 32'h100);
        check("fwd_status", 32'(status_q), 32'h3);
        tick;
        check("fwd_pulse", 32'(bex_taken), 32'h0);
        check("fwd_pc_hold", 32'(bex_pc), 32'h100);

        // Clear priority
        push(27'h1);
        check("clr_pre_status", 32'(status_q), 32'h1);
        status_clr = 1'b1; bex_valid = 1'b1; bex_target = 27'h200;
        tick;
        bex_valid = 1'b0; bex_target = '0;
        check("clr_taken", 32'(bex_taken), 32'h0);
        check("clr_status", 32'(status_q), 32'h0);
        check("clr_pc_hold", 32'(bex_pc), 32'h100);
        status_we = 1'b1; status_in = 27'h2;
        tick;
        status_we = 1'b0; status_in = '0; status_clr = 1'b0;
        check("we_over_clr", 32'(status_q), 32'h2);
        bex_valid = 1'b1; bex_target = 27'h7ABCDE;
        tick;
        bex_valid = 1'b0; bex_target = '0;
        check("bex_q_taken", 32'(bex_taken), 32'h1);
        check("bex_q_pc", 32'(bex_pc), 32'h7ABCDE);

        // Reset mid-stream with 3 events queued
        check("mid_count", 32'(evt_count), 32'd3);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_rst_status", 32'(status_q), 32'h0);
        check("mid_rst_valid", 32'(evt_valid), 32'h0);
        check("mid_rst_count", 32'(evt_count), 32'h0);
        check("mid_rst_drop", 32'(drop_count), 32'h0);
        check("mid_rst_pc", 32'(bex_pc), 32'h0);
        check("mid_rst_code", 32'(evt_code), 32'h0);
        push(27'h5);
        check("ts_restart_code", 32'(evt_code), 32'h5);
        check("ts_restart_time", 32'(evt_time), 32'h0);
        check("ts_restart_count", 32'(evt_count), 32'd1);

        // Overflow and drop
        push(27'h6);
        push(27'h7);
        push(27'h8);
        push(27'h9);
        push(27'hA);
        push(27'hB);
        check("ovf_drop", 32'(drop_count), 32'd3);
        check("ovf_count", 32'(evt_count), 32'd4);
        check("ovf_head_code", 32'(evt_code), 32'h5);
        check("ovf_head_time", 32'(evt_time), 32'h0);
        evt_ready = 1'b1;
        push(27'hC);
        evt_ready = 1'b0;
        check("fullpp_drop", 32'(drop_count), 32'd3);
        check("fullpp_count", 32'(evt_count), 32'd4);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain2_code", 32'(evt_code), 32'(exp_code2[i]));
            check("drain2_time", 32'(evt_time), 32'(exp_time2[i]));
            tick;
        end
        evt_ready = 1'b0;
        check("drain2_valid", 32'(evt_valid), 32'h0);

        // Drop counter saturation: 300 dropped pushes on top of 3
        for (int i = 0; i < 4; i++) push(27'h20 + 27'(i));
        for (int i = 0; i < 249; i++) push(27'h40);
        check("sat_252", 32'(drop_count), 32'd252);
        for (int i = 0; i < 3; i++) push(27'h40);
        check("sat_255", 32'(drop_count), 32'd255);
        for (int i = 0; i < 48; i++) push(27'h40);
        check("sat_hold", 32'(drop_count), 32'd255);
        check("sat_count", 32'(evt_count), 32'd4);
        check("sat_head", 32'(evt_code), 32'h20);

        // Timestamp wrap: event logged when the counter has wrapped to 0
        evt_ready = 1'b1;
        repeat (4) tick;
        evt_ready = 1'b0;
        for (int i = 0; i < 70000 && ts != 16'd0; i++) tick;
        push(27'h9);
        check("wrap_code", 32'(evt_code), 32'h9);
        check("wrap_time", 32'(evt_time), 32'h0);
        check("wrap_count", 32'(evt_count), 32'd1);
        check("wrap_drop", 32'(drop_count), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/status_monitor.md
Name: status_monitor

Overview:
Consumer side of the processor status register (rstatus). It captures status writes produced by the status-assignment logic (overflow codes 1=add, 2=addi, 3=sub; setx target values), holds the architectural status value, and resolves bex (branch-if-status-nonzero) with write forwarding. It also logs every nonzero status write, with a timestamp, into a small event FIFO. The debug/display path drains that FIFO through a valid/ready handshake.

Parameters:
DEPTH, 4, event FIFO entries; power of two, minimum 2
TS_W, 16, timestamp counter width
DROP_W, 8, dropped-event counter width

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
status_we  in  1  status register write strobe
status_in  in  27  value to write (overflow code or setx target)
status_clr  in  1  clear status register to 0
bex_valid  in  1  bex instruction present this cycle
bex_target  in  27  bex branch target
bex_taken  out  1  registered one-cycle pulse, branch taken
bex_pc  out  27  target of the most recent taken bex
status_q  out  27  current status register value
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head
evt_code  out  27  status value of the head entry
evt_time  out  TS_W  timestamp of the head entry
evt_count  out  clog2(DEPTH)+1  current occupancy
drop_count  out  DROP_W  events lost to a full FIFO, saturating

Behaviour:
- Reset (synchronous, active-high, also mid-operation): status_q=0, bex_taken=0, bex_pc=0, FIFO emptied (evt_valid=0, evt_count=0), drop_count=0, timestamp=0. evt_code/evt_time read as 0 while empty.
- Timestamp: free-running TS_W counter, +1 every cycle, wraps 2^TS_W-1 -> 0.
- Status write: status_we=1 -> status_q <= status_in next edge. Writing 0 is legal; it updates status_q but logs no event.
- Clear: status_clr=1 with status_we=0 -> status_q <= 0. If both are 1, status_we wins.
- bex evaluation, one-cycle latency:
  - effective = status_in if status_we=1 (forwarded), else 0 if status_clr=1, else status_q.
  - bex_valid=1 and effective!=0 -> next cycle bex_taken=1 and bex_pc <= bex_target.
  - Otherwise bex_taken=0 next cycle and bex_pc holds.
  - bex_taken is never held longer than one cycle per bex_valid cycle.
- Event push: status_we=1 and status_in!=0 -> push {status_in, timestamp of that cycle}.
- Event pop: evt_valid=1 and evt_ready=1 -> head removed at the edge, next entry presented next cycle. evt_ready while empty has no effect.
- Full, push without pop: event discarded, drop_count += 1, saturating at 2^DROP_W-1. Existing contents unchanged.
- Full, push with pop in the same cycle: both happen, no drop, count stays DEPTH.
- Empty, push: evt_valid rises the next cycle. No same-cycle fall-through.
- Simultaneous push and pop, not full: count unchanged, ordering preserved.
- FIFO order is strict first-in first-out. Read and write pointers wrap modulo DEPTH. Full/empty is derived from evt_count.
- evt_code and evt_time are stable while evt_valid=1 and evt_ready=0.

Test Plan:
- Reset mid-stream: 3 events queued, status_q=2, then reset 1 cycle -> status_q=0, evt_valid=0, evt_count=0, drop_count=0, timestamp restarts at 0.
- Forwarding: status_q=0; same cycle status_we=1, status_in=3, bex_valid=1, bex_target=27'h100 -> next cycle bex_taken=1, bex_pc=27'h100, status_q=3.
- Clear priority: status_q=1; status_clr=1, bex_valid=1 -> bex_taken=0, status_q=0. Then status_clr=1 and status_we=1 with status_in=2 together -> status_q=2.
- FIFO order and timestamps, DEPTH=4:
  - Writes 1, 0, 2, 27'h0F1, 3 at t=5..9 -> 4 events logged; value 0 is skipped.
  - Drain with evt_ready=1 -> (1,t5), (2,t7), (0F1,t8), (3,t9).
  - After the last pop, evt_valid=0.
- Overflow/drop: fill 4 entries, evt_ready=0, 3 more nonzero writes -> drop_count=3, head unchanged. Next push with concurrent pop -> drop_count stays 3, evt_count=4.
- Saturation and wrap:
  - 300 dropped pushes -> drop_count=255.
  - With TS_W=16, an event at cycle 65536 -> evt_time=0.
